// File: rtl/network_bank_out.sv
// Bank-to-lane return crossbar: delays the lane selects by the bank read latency, then inverts them.
// Define NETWORK_BANK_OUT_PERM_CHK_EN to build the permutation-error flag; otherwise perm_err is tied low.
module network_bank_out #(
  parameter int addr_width = 8,
  parameter int data_width = 12,
  parameter int RD_LAT     = 1
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  valid_in,
  input  logic [1:0]            sel_a_0,
  input  logic [1:0]            sel_a_1,
  input  logic [1:0]            sel_a_2,
  input  logic [1:0]            sel_a_3,
  input  logic [data_width-1:0] q0,
  input  logic [data_width-1:0] q1,
  input  logic [data_width-1:0] q2,
  input  logic [data_width-1:0] q3,
  output logic [data_width-1:0] d0,
  output logic [data_width-1:0] d1,
  output logic [data_width-1:0] d2,
  output logic [data_width-1:0] d3,
  output logic                  valid_out,
  output logic                  perm_err
);

  // addr_width only keeps the parameter list shared with the address network.
  localparam int LastStage = RD_LAT - 1 + 0 * addr_width;

  logic                  validLine_q [RD_LAT];
  logic [3:0][1:0]       selLine_q   [RD_LAT];
  logic [3:0][data_width-1:0] bankData;
  logic [3:0][1:0]       lastSel;
  logic                  lastValid;
  logic [3:0][data_width-1:0] dOut_d, dOut_q;
  logic                  validOut_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int s = 0; s < RD_LAT; s++) begin
        validLine_q[s] <= 1'b0;
        selLine_q[s]   <= '0;
      end
    end else begin
      validLine_q[0] <= valid_in;
      selLine_q[0]   <= {sel_a_3, sel_a_2, sel_a_1, sel_a_0};
      for (int s = 1; s < RD_LAT; s++) begin
        validLine_q[s] <= validLine_q[s-1];
        selLine_q[s]   <= selLine_q[s-1];
      end
    end
  end

  assign bankData  = {q3, q2, q1, q0};
  assign lastSel   = selLine_q[LastStage];
  assign lastValid = validLine_q[LastStage];

  // Scanning banks from high to low lets the lowest matching bank win the lane.
  always_comb begin
    dOut_d = '0;
    for (int j = 0; j < 4; j++) begin
      for (int k = 3; k >= 0; k--) begin
        if (lastSel[k] == 2'(j)) begin
          dOut_d[j] = bankData[k];
        end
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      dOut_q     <= '0;
      validOut_q <= 1'b0;
    end else begin
      validOut_q <= lastValid;
      if (lastValid) begin
        dOut_q <= dOut_d;
      end
    end
  end

`ifdef NETWORK_BANK_OUT_PERM_CHK_EN
  logic [3:0][3:0] hit;
  logic            permErr_d, permErr_q;

  // A lane with zero hits or with several hits means the selects were not a permutation.
  always_comb begin
    hit       = '0;
    permErr_d = 1'b0;
    for (int j = 0; j < 4; j++) begin
      for (int k = 0; k < 4; k++) begin
        hit[j][k] = (lastSel[k] == 2'(j));
      end
      if (hit[j] == 4'b0 || (hit[j] & (hit[j] - 4'd1)) != 4'b0) begin
        permErr_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      permErr_q <= 1'b0;
    end else if (lastValid) begin
      permErr_q <= permErr_d;
    end
  end

  assign perm_err = permErr_q;
`else
  assign perm_err = 1'b0;
`endif

  assign d0        = dOut_q[0];
  assign d1        = dOut_q[1];
  assign d2        = dOut_q[2];
  assign d3        = dOut_q[3];
  assign valid_out = validOut_q;

endmodule

// File: doc/network_bank_out.md
# network_bank_out

Return-path crossbar for the multi-lane NTT memory subsystem: routes read data from the four memory banks back to the four butterfly lanes. It is the inverse of the lane-to-bank address network, which drives bank k with the address of lane sel_a_k. The block captures the same sel_a_0..3 used for the address issue and delays them to match the bank read latency. It then inverts the permutation, so lane j receives the data of the bank whose select equals j. Outputs are registered, with a valid flag and a permutation-error flag.

## Interface
- addr_width, 8 — not used for logic; kept so address and data networks share one parameter list.
- data_width, 12 — width of the bank read data and the lane data.
- RD_LAT, 1 — bank read latency in cycles, from the address-sampling edge to stable q; legal values 1..4.

- clk  input  1  — single clock, rising edge.
- rst  input  1  — asynchronous, active-high reset.
- valid_in  input  1  — a read is issued this cycle with sel_a_0..3.
- sel_a_0, sel_a_1, sel_a_2, sel_a_3  input  2 each — the same lane-select values given to the address network this cycle; bank k is served by lane sel_a_k.
- q0, q1, q2, q3  input  data_width each — bank read data.
- d0, d1, d2, d3  output  data_width each — registered lane data; d_j comes from bank k where sel_a_k == j.
- valid_out  output  1 — d0..d3 carry the data for a read issued RD_LAT cycles earlier.
- perm_err  output  1 — the sel_a set of the delivered read was not a permutation.

## Operation
- Select delay line: RD_LAT stages, each holding {valid, sel_a_0..3}. Stage 0 loads at every edge, and a bubble loads when valid_in=0. The line is never stalled.
- Inversion, combinational on the last stage, for each lane j:
  - hit_j,k = (sel_k == j).
  - src_j = lowest k with hit_j,k.
  - If no k hits, lane j has no source.
- Output register, loaded only when the last-stage valid is 1:
  - d_j ← q[src_j], or 0 when lane j has no source.
  - perm_err ← 1 when any lane has no source or any lane has two or more hits; otherwise 0.
- When the last-stage valid is 0, d0..d3 and perm_err hold their previous values.
- valid_out ← last-stage valid, every edge.
- Back-to-back reads with valid_in=1 every cycle are fully supported; throughput is one read per cycle.

## Timing
- Reset (rst=1, asynchronous): all delay stages are cleared (valid=0, sel=0), and d0..d3=0, valid_out=0, perm_err=0. These hold until the first rising edge after rst falls.
- Latency: for a read sampled at edge E0, valid_out and d0..d3 are valid in the cycle after edge E0+RD_LAT.
- q0..q3 must be stable in the cycle before edge E0+RD_LAT. That is the bank's RD_LAT-cycle read contract.
- Reset asserted mid-operation flushes all in-flight reads. No valid_out pulse occurs for reads sampled before reset.
- The inversion is a single 4-way priority mux per lane, placed before the output register. There is no additional pipeline stage.

## Configuration
- NETWORK_BANK_OUT_PERM_CHK_EN defined: perm_err is computed as described above.
- NETWORK_BANK_OUT_PERM_CHK_EN undefined:
  - The check logic is omitted and perm_err is tied to 0.
  - Routing is unchanged: lowest-index priority, and 0 for a lane with no source.

## Test plan
- Reset value: assert rst asynchronously mid-cycle with a read in flight -> d0..d3=0, valid_out=0, perm_err=0 immediately; no valid_out pulse after release.
- Identity (RD_LAT=1): sel=0,1,2,3, q=0x111,0x222,0x333,0x444 -> the next cycle has valid_out=1 and d0..d3=0x111,0x222,0x333,0x444, perm_err=0.
- Rotation (RD_LAT=2): sel_a_0..3=1,2,3,0, q=0xA,0xB,0xC,0xD aligned two cycles later -> d0=0xD, d1=0xA, d2=0xB, d3=0xC, valid_out asserted exactly RD_LAT cycles after issue.
- Streaming: 8 consecutive valid reads with a different permutation each cycle, then one bubble, then 2 reads -> 8 contiguous valid_out pulses each correctly routed, one low cycle, and the held d values unchanged during the bubble.
- Non-permutation: sel=0,0,2,3, q=5,6,7,8 -> d0=5, d1=0, d2=7, d3=8, perm_err=1 when the check is enabled and 0 when disabled.
- Reset mid-stream with RD_LAT=3: 3 reads in flight, then rst pulsed -> zero valid_out pulses for those reads, and the first post-reset read is routed correctly.
